// File: rtl/sha3_round_sequencer.sv
// sha3_round_sequencer
// Drives ROUNDS Keccak-f rounds through an external, shared round datapath.
// The full 1600-bit state is held here; each round is launched with a
// one-cycle rsample pulse and the result is taken back when rgood arrives.
// Lane order on every 5x64 bus is x = 0..4 within plane y (a=0 .. e=4).
//
// Optional build macro: SHA3_SEQ_WATCHDOG_EN
//   Adds the sticky err output and a watchdog on the WAIT state that abandons
//   the hash after TIMEOUT cycles without rgood. Without it, WAIT never times out.
module sha3_round_sequencer #(
  parameter int ROUNDS        = 24,
  parameter int ROUND_LATENCY = 0,
  parameter int TIMEOUT       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  output logic             busy,
  output logic [4:0]       round_index,
  output logic [4:0][63:0] rsa,
  output logic [4:0][63:0] rsb,
  output logic [4:0][63:0] rsc,
  output logic [4:0][63:0] rsd,
  output logic [4:0][63:0] rse,
  output logic             rsample,
  input  logic [4:0][63:0] rin_a,
  input  logic [4:0][63:0] rin_b,
  input  logic [4:0][63:0] rin_c,
  input  logic [4:0][63:0] rin_d,
  input  logic [4:0][63:0] rin_e,
  input  logic             rgood,
  output logic [4:0][63:0] osa,
  output logic [4:0][63:0] osb,
  output logic [4:0][63:0] osc,
  output logic [4:0][63:0] osd,
  output logic [4:0][63:0] ose,
  output logic             ogood
`ifdef SHA3_SEQ_WATCHDOG_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  // An out-of-range configuration leaves the block inert rather than letting
  // round_index run past a meaningful final round.
  localparam bit CFG_OK = (ROUNDS >= 1) && (ROUNDS <= 24) &&
                          (ROUND_LATENCY >= 0) && (TIMEOUT >= 1);

  // With a zero-latency datapath the result comes back in the launch cycle,
  // so the launch cycle itself is the first cycle of the wait window.
  localparam bit ISSUE_ACCEPTS = (ROUND_LATENCY == 0);

`ifdef SHA3_SEQ_WATCHDOG_EN
  localparam int            WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt_reg;
`endif

  state_t            fsm_reg;
  logic [24:0][63:0] lanes_reg;
  logic [24:0][63:0] out_reg;
  logic [24:0][63:0] in_lanes;
  logic [24:0][63:0] rin_lanes;
  logic              round_done;

  assign in_lanes  = {ise, isd, isc, isb, isa};
  assign rin_lanes = {rin_e, rin_d, rin_c, rin_b, rin_a};
  assign {rse, rsd, rsc, rsb, rsa} = lanes_reg;
  assign {ose, osd, osc, osb, osa} = out_reg;

  // A round result is only taken while a round is outstanding.
  assign round_done = rgood &&
                      ((fsm_reg == WAIT) || (ISSUE_ACCEPTS && (fsm_reg == ISSUE)));

  // Sequencer FSM; busy, rsample and ogood are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg     <= IDLE;
      lanes_reg   <= '0;
      out_reg     <= '0;
      round_index <= '0;
      busy        <= 1'b0;
      rsample     <= 1'b0;
      ogood       <= 1'b0;
`ifdef SHA3_SEQ_WATCHDOG_EN
      wd_cnt_reg  <= '0;
      err         <= 1'b0;
`endif
    end else begin
      rsample <= 1'b0;
      ogood   <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start && CFG_OK) begin
            lanes_reg   <= in_lanes;
            round_index <= '0;
            busy        <= 1'b1;
            rsample     <= 1'b1;
            fsm_reg     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (round_done) begin
            lanes_reg <= rin_lanes;
            if (round_index == LAST_ROUND) begin
              out_reg <= rin_lanes;
              ogood   <= 1'b1;
              fsm_reg <= DONE;
            end else begin
              round_index <= round_index + 5'd1;
              rsample     <= 1'b1;
              fsm_reg     <= ISSUE;
            end
          end else if (fsm_reg == ISSUE) begin
            fsm_reg <= WAIT;
`ifdef SHA3_SEQ_WATCHDOG_EN
            wd_cnt_reg <= '0;
`endif
          end
`ifdef SHA3_SEQ_WATCHDOG_EN
          else if (wd_cnt_reg == WD_LAST) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            fsm_reg <= IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
          end
`endif
        end
        DONE: begin
          busy    <= 1'b0;
          fsm_reg <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha3_round_sequencer.md
SHA3_ROUND_SEQUENCER -- requirements
Module: sha3_round_sequencer

Interface
REQ-001 The parameter ROUNDS SHALL default to 24 and set the Keccak-f rounds per hash, legal range 1..24.
REQ-002 The parameter ROUND_LATENCY SHALL default to 0 and set the shared round datapath latency from rsample to rgood, in cycles.
REQ-003 The parameter TIMEOUT SHALL default to 64 and set the watchdog limit in cycles (used only under REQ-030).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  request to hash the state on isa..ise; accepted only when busy=0.
REQ-007 isa, isb, isc, isd, ise  in  64x5 each  initial 1600-bit Keccak state.
REQ-008 busy  out  1  high from the cycle after acceptance through the ogood cycle.
REQ-009 round_index  out  5  round currently issued to the datapath.
REQ-010 rsa, rsb, rsc, rsd, rse  out  64x5 each  state register driven to the datapath.
REQ-011 rsample  out  1  single-cycle pulse launching one round.
REQ-012 rin_a..rin_e  in  64x5 each  round result from the datapath.
REQ-013 rgood  in  1  round result valid.
REQ-014 osa, osb, osc, osd, ose  out  64x5 each  final state, valid while ogood=1.
REQ-015 ogood  out  1  single-cycle pulse marking final state valid.
REQ-016 err  out  1  sticky watchdog error (present only under REQ-030).

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE, start=1: capture isa..ise into the state register, clear round_index to 0, go to ISSUE.
REQ-019 ISSUE: assert rsample for one cycle with rsa..rse = state register, go to WAIT.
REQ-020 WAIT, rgood=1: load rin_a..rin_e into the state register; round_index=ROUNDS-1 -> DONE, otherwise increment round_index and go to ISSUE.
REQ-021 DONE: ogood=1 for one cycle, osa..ose = state register, then IDLE.
REQ-022 Timing: each round SHALL take ROUND_LATENCY+1 cycles (with ROUND_LATENCY=0, rgood in the rsample cycle is accepted at that edge); start accepted at edge 0 -> ogood high in cycle ROUNDS*(ROUND_LATENCY+1)+1.
REQ-023 A start arriving in any state other than IDLE SHALL be ignored, with no queueing.
REQ-024 An rgood arriving in any state other than WAIT SHALL be ignored and leave the state register unchanged.
REQ-025 round_index SHALL never exceed ROUNDS-1 and SHALL never wrap within a hash.
REQ-026 start in the cycle after ogood SHALL be accepted, giving back-to-back hashes with no bubble beyond DONE.
REQ-027 osa..ose SHALL hold the last final state until the next DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force: FSM to IDLE, round_index 0, busy 0, rsample 0, ogood 0, state register and osa..ose all-zero, err 0.
REQ-029 Reset mid-hash SHALL abandon the hash with no ogood, and an rgood arriving after release SHALL be ignored per REQ-024.

Configuration
REQ-030 With SHA3_SEQ_WATCHDOG_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT cycles without rgood sets err=1 (sticky until reset) and returns the FSM to IDLE with no ogood. Without the macro, err SHALL be absent and WAIT SHALL wait indefinitely.

Verification
REQ-031 All-zero input, ROUNDS=24, ROUND_LATENCY=0, Keccak round model -> ogood in cycle 25, osa[0]=0xF1258F7940E1DDE7.
REQ-032 Same input with ROUND_LATENCY=2 -> exactly 24 rsample pulses 3 cycles apart, round_index 0..23, ogood in cycle 73, identical output.
REQ-033 Second start issued 5 cycles after the first -> ignored; exactly one ogood; busy stays 1 throughout.
REQ-034 rst_n low while round_index=10 -> busy, rsample, ogood and round_index go to 0 at once; no ogood follows; the next start completes normally.
REQ-035 SHA3_SEQ_WATCHDOG_EN defined, TIMEOUT=64, model withholds rgood on round 3 -> err=1 64 cycles into WAIT, FSM IDLE, no ogood.
